// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - shared types for the ALU arbiter: FSM states, requester count, ALU opcodes.
package definitions;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_t;

  typedef enum logic [3:0] {
    add_immediate      = 4'h0,
    sub_register       = 4'h1,
    and_register       = 4'h2,
    or_register        = 4'h3,
    xor_register       = 4'h4,
    left_shift         = 4'h5,
    right_shift        = 4'h6,
    reduced_xor        = 4'h7,
    not_equal_register = 4'h8
  } op_mne_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// rtl/alu_arbiter_alu.sv - combinational ALU shared by the arbiter's requesters.
module alu_arbiter_alu
  import definitions::*;
#(
  parameter int W   = 8,
  parameter int Ops = 4
) (
  input  logic [Ops-1:0] i_op,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic [W-1:0]   o_out
);

  // Shifts act on InputB by one place; compare/reduce results are zero-extended.
  always_comb begin
    o_out = '0;
    case (i_op)
      Ops'(add_immediate):      o_out = i_a + i_b;
      Ops'(sub_register):       o_out = i_a - i_b;
      Ops'(and_register):       o_out = i_a & i_b;
      Ops'(or_register):        o_out = i_a | i_b;
      Ops'(xor_register):       o_out = i_a ^ i_b;
      Ops'(left_shift):         o_out = i_b << 1;
      Ops'(right_shift):        o_out = i_b >> 1;
      Ops'(reduced_xor):        o_out = {{(W-1){1'b0}}, ^i_b};
      Ops'(not_equal_register): o_out = {{(W-1){1'b0}}, (i_a != i_b)};
      default:                  o_out = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter that sequences two requesters through one shared ALU.
module alu_arbiter
  import definitions::*;
#(
  parameter int W   = 8,
  parameter int Ops = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input  logic [Ops-1:0]     req_op0,
  input  logic [Ops-1:0]     req_op1,
  input  logic [W-1:0]       req_a0,
  input  logic [W-1:0]       req_a1,
  input  logic [W-1:0]       req_b0,
  input  logic [W-1:0]       req_b1,
  output logic [NUM_REQ-1:0] rsp_valid,
  input  logic [NUM_REQ-1:0] rsp_ready,
  output logic [W-1:0]       rsp_data,
  output logic               busy
);

  arb_state_t         r_state;
  logic               r_prio;
  logic               r_gnt;
  logic [Ops-1:0]     r_op;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic [W-1:0]       r_res;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic               r_busy;

  logic               w_gnt;
  logic [NUM_REQ-1:0] w_req_ready;
  logic               w_accept;
  logic [W-1:0]       w_alu_out;

  // Tie goes to the pointer; otherwise the single active requester (bit 1 decides).
  always_comb begin
    w_gnt       = (req_valid == 2'b11) ? r_prio : req_valid[1];
    w_req_ready = '0;
    if (rst_n && (r_state == IDLE) && req_valid[w_gnt])
      w_req_ready[w_gnt] = 1'b1;
    w_accept    = |(req_valid & w_req_ready);
  end

  alu_arbiter_alu #(
    .W   (W),
    .Ops (Ops)
  ) u_alu (
    .i_op  (r_op),
    .i_a   (r_a),
    .i_b   (r_b),
    .o_out (w_alu_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_prio      <= 1'b0;
      r_gnt       <= 1'b0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_res       <= '0;
      r_rsp_valid <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op    <= w_gnt ? req_op1 : req_op0;
            r_a     <= w_gnt ? req_a1 : req_a0;
            r_b     <= w_gnt ? req_b1 : req_b0;
            r_gnt   <= w_gnt;
            r_busy  <= 1'b1;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_res       <= w_alu_out;
          r_rsp_valid <= r_gnt ? 2'b10 : 2'b01;
          r_state     <= RESP;
        end
        RESP: begin
          // Only the granted requester's accept completes the response.
          if (rsp_ready[r_gnt]) begin
            r_prio      <= ~r_gnt;
            r_rsp_valid <= '0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_rsp_valid <= '0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = w_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_res;
  assign busy      = r_busy;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with an expected-response queue.
module tb_alu_arbiter;
  import definitions::*;

  typedef struct {
    logic       idx;
    logic [7:0] data;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [3:0] req_op0, req_op1;
  logic [7:0] req_a0, req_a1, req_b0, req_b1;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready;
  logic [7:0] rsp_data;
  logic       busy;

  exp_t exp_q[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;

  alu_arbiter #(.W(8), .Ops(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op0   (req_op0),
    .req_op1   (req_op1),
    .req_a0    (req_a0),
    .req_a1    (req_a1),
    .req_b0    (req_b0),
    .req_b1    (req_b1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid = 2'b00;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    repeat (3) step();
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
    checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (rsp_data !== 8'h00) begin failures++; $display("FAIL reset_rsp_data got=%h exp=00", rsp_data); end
    rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL reset_first_grant got=%b exp=01", req_ready); end
    req_valid = 2'b00;
    #1;
  endtask

  task automatic test_single();
    req_op0 = add_immediate; req_a0 = 8'h05; req_b0 = 8'h03;
    rsp_ready = 2'b01;
    req_valid = 2'b01;
    exp_q.push_back('{1'b0, 8'h08});
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL single_req_ready got=%b exp=01", req_ready); end
    step();
    req_valid = 2'b00;
    checks++; if (busy !== 1'b1 || rsp_valid !== 2'b00) begin failures++; $display("FAIL single_exec got busy=%b rsp_valid=%b exp busy=1 rsp_valid=00", busy, rsp_valid); end
    step();
    e = exp_q.pop_front();
    checks++; if (rsp_valid !== 2'b01) begin failures++; $display("FAIL single_rsp_valid got=%b exp=01", rsp_valid); end
    checks++; if (rsp_data !== e.data) begin failures++; $display("FAIL single_rsp_data got=%h exp=%h", rsp_data, e.data); end
    step();
    checks++; if (busy !== 1'b0 || rsp_valid !== 2'b00) begin failures++; $display("FAIL single_idle got busy=%b rsp_valid=%b exp busy=0 rsp_valid=00", busy, rsp_valid); end
  endtask

  task automatic test_contention();
    logic [1:0] exp_v;
    apply_reset();
    req_op0 = xor_register; req_a0 = 8'hF0; req_b0 = 8'h3C;
    req_op1 = or_register;  req_a1 = 8'h0F; req_b1 = 8'h30;
    rsp_ready = 2'b11;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('{1'b0, 8'hCC});
      exp_q.push_back('{1'b1, 8'h3F});
    end
    req_valid = 2'b11;
    for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
      step();
      if (rsp_valid !== 2'b00) begin
        e = exp_q.pop_front();
        exp_v = e.idx ? 2'b10 : 2'b01;
        checks++; if (rsp_valid !== exp_v) begin failures++; $display("FAIL contention_order got=%b exp=%b", rsp_valid, exp_v); end
        checks++; if (rsp_data !== e.data) begin failures++; $display("FAIL contention_data got=%h exp=%h", rsp_data, e.data); end
      end
    end
    req_valid = 2'b00;
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL contention_timeout got=%0d pending exp=0", exp_q.size()); exp_q.delete(); end
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL contention_idle got busy=%b exp=0", busy); end
  endtask

  task automatic test_backpressure();
    req_op1 = left_shift; req_a1 = 8'h00; req_b1 = 8'h81;
    rsp_ready = 2'b01;
    req_valid = 2'b10;
    exp_q.push_back('{1'b1, 8'h02});
    #1;
    checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL bp_req_ready got=%b exp=10", req_ready); end
    step();
    req_valid = 2'b01;
    req_op0 = add_immediate; req_a0 = 8'h10; req_b0 = 8'h20;
    step();
    for (int i = 0; i < 4; i++) begin
      checks++; if (rsp_valid !== 2'b10) begin failures++; $display("FAIL bp_hold_valid cycle %0d got=%b exp=10", i, rsp_valid); end
      checks++; if (rsp_data !== exp_q[0].data) begin failures++; $display("FAIL bp_hold_data cycle %0d got=%h exp=%h", i, rsp_data, exp_q[0].data); end
      checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL bp_no_grant cycle %0d got=%b exp=00", i, req_ready); end
      step();
    end
    rsp_ready = 2'b10;
    e = exp_q.pop_front();
    checks++; if (rsp_valid !== 2'b10 || rsp_data !== e.data) begin failures++; $display("FAIL bp_release got valid=%b data=%h exp valid=10 data=%h", rsp_valid, rsp_data, e.data); end
    exp_q.push_back('{1'b0, 8'h30});
    step();
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL bp_pending_grant got=%b exp=01", req_ready); end
    step();
    req_valid = 2'b00;
    rsp_ready = 2'b01;
    step();
    e = exp_q.pop_front();
    checks++; if (rsp_valid !== 2'b01 || rsp_data !== e.data) begin failures++; $display("FAIL bp_pending_rsp got valid=%b data=%h exp valid=01 data=%h", rsp_valid, rsp_data, e.data); end
    step();
  endtask

  task automatic test_width();
    logic [3:0] ops [4];
    logic [7:0] av [4];
    logic [7:0] bv [4];
    logic [7:0] ev [4];
    logic       got;
    ops = '{add_immediate, not_equal_register, reduced_xor, 4'hF};
    av  = '{8'hFF, 8'h5A, 8'h00, 8'h12};
    bv  = '{8'h02, 8'h5A, 8'h07, 8'h34};
    ev  = '{8'h01, 8'h00, 8'h01, 8'h00};
    rsp_ready = 2'b01;
    for (int i = 0; i < 4; i++) begin
      req_op0 = ops[i]; req_a0 = av[i]; req_b0 = bv[i];
      req_valid = 2'b01;
      exp_q.push_back('{1'b0, ev[i]});
      step();
      req_valid = 2'b00;
      got = 1'b0;
      for (int c = 0; c < 6; c++) begin
        if (rsp_valid !== 2'b00) begin got = 1'b1; break; end
        step();
      end
      e = exp_q.pop_front();
      checks++; if (got !== 1'b1) begin failures++; $display("FAIL width_timeout case %0d got no response exp response", i); end
      else begin
        checks++; if (rsp_data !== e.data) begin failures++; $display("FAIL width_data case %0d got=%h exp=%h", i, rsp_data, e.data); end
      end
      step();
    end
  endtask

  task automatic test_midop_reset();
    req_op0 = add_immediate; req_a0 = 8'h01; req_b0 = 8'h01;
    rsp_ready = 2'b00;
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midop_exec_busy got=%b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 2'b00 || busy !== 1'b0 || req_ready !== 2'b00) begin failures++; $display("FAIL midop_exec_reset got valid=%b busy=%b ready=%b exp 00/0/00", rsp_valid, busy, req_ready); end
    step();
    rst_n = 1'b1;
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    step();
    checks++; if (rsp_valid !== 2'b01) begin failures++; $display("FAIL midop_resp_entry got=%b exp=01", rsp_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin failures++; $display("FAIL midop_resp_reset got valid=%b busy=%b exp 00/0", rsp_valid, busy); end
    step();
    rst_n = 1'b1;
    rsp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL midop_no_rsp cycle %0d got=%b exp=00", i, rsp_valid); end
    end
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL midop_prio got=%b exp=01", req_ready); end
    req_valid = 2'b00;
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_op0 = '0; req_op1 = '0;
    req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_width();
    test_midop_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
